// File: rtl/y_sram_pkg.sv
// Shared definitions for the Y SRAM bus cluster (scheduler, bus-mux, path
// controllers).
//
// Contents:
//   TIMEOUT_DEFAULT  default forced-release limit of one grant, in cycles
//   WDOG_W_DEFAULT   default watchdog counter width
//   sched_state_t    bus scheduler FSM states
//   bus_src_t        requester identity, also the encoding of op_timeoutSrc
package y_sram_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;
    localparam int unsigned WDOG_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_C = 2'd1,
        GNT_W = 2'd2,
        TURN  = 2'd3
    } sched_state_t;

    typedef enum logic {
        SRC_COMPUTE = 1'b0,
        SRC_WRITE   = 1'b1
    } bus_src_t;

endpackage

// File: rtl/y_bus_sched_wdog.sv
// Grant watchdog for the Y bus scheduler.
//
// Counts the cycles a grant has been held. The count sits at zero while clear
// is high, so it always starts from zero on the first cycle of a grant. expire
// is high on the TIMEOUT-th cycle of a grant (count == TIMEOUT-1).
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-low reset
//   clear   hold the count at zero (scheduler is not in a grant state)
//   enable  count this cycle (scheduler is in a grant state)
//   expire  grant has reached its cycle limit
module y_sched_wdog
    import y_sram_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned WDOG_W  = WDOG_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            // Saturating: the scheduler leaves the grant on expiry anyway.
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/y_bus_sched.sv
// Y SRAM bus scheduler: arbitrates the Y bus between the compute path and the
// write path.
//
// A single request is granted one cycle later. When both paths request in
// IDLE, the one not served by the most recent grant wins (write wins the first
// tie after reset). A grant ends on done, on request drop, or by watchdog
// expiry after TIMEOUT cycles. Every grant is followed by one TURN cycle with
// both enables low so in-flight SRAM writes drain before the mux switches.
// Outputs are decoded from state or come straight from flops.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous, active-low reset
//   in_computeReq            compute path requests the bus
//   in_computeDone           pulse: compute path finished its burst
//   in_writeReq              write path requests the bus
//   in_writeDone             pulse: write path finished its burst
//   in_errClear              clears the sticky timeout error
//   op_yComputeModuleEnable  compute mux select / grant
//   op_yWriteModuleEnable    write mux select / grant
//   op_busy                  FSM not in IDLE
//   op_timeoutErr            sticky: a grant was force-released
//   op_timeoutSrc            source of last timeout (0 compute, 1 write)
module y_bus_sched
    import y_sram_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned WDOG_W  = WDOG_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic in_computeReq,
    input  logic in_computeDone,
    input  logic in_writeReq,
    input  logic in_writeDone,
    input  logic in_errClear,
    output logic op_yComputeModuleEnable,
    output logic op_yWriteModuleEnable,
    output logic op_busy,
    output logic op_timeoutErr,
    output logic op_timeoutSrc
);

    sched_state_t state, state_nxt;
    bus_src_t     last_grant;
    logic         in_gnt;
    logic         expire;
    logic         timeout_hit;

    assign in_gnt = (state == GNT_C) || (state == GNT_W);

    y_sched_wdog #(
        .TIMEOUT (TIMEOUT),
        .WDOG_W  (WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_gnt),
        .enable (in_gnt),
        .expire (expire)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_computeReq && in_writeReq) begin
                    state_nxt = (last_grant == SRC_WRITE) ? GNT_C : GNT_W;
                end else if (in_computeReq) begin
                    state_nxt = GNT_C;
                end else if (in_writeReq) begin
                    state_nxt = GNT_W;
                end
            end
            GNT_C: begin
                // Release by the owner beats a same-cycle watchdog expiry.
                if (in_computeDone || !in_computeReq) begin
                    state_nxt = TURN;
                end else if (expire) begin
                    state_nxt   = TURN;
                    timeout_hit = 1'b1;
                end
            end
            GNT_W: begin
                if (in_writeDone || !in_writeReq) begin
                    state_nxt = TURN;
                end else if (expire) begin
                    state_nxt   = TURN;
                    timeout_hit = 1'b1;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= SRC_COMPUTE;
            op_timeoutErr <= 1'b0;
            op_timeoutSrc <= 1'b0;
        end else begin
            state <= state_nxt;

            // Pointer moves on every grant entry, whatever later ends it.
            if (state == IDLE && state_nxt == GNT_C) begin
                last_grant <= SRC_COMPUTE;
            end else if (state == IDLE && state_nxt == GNT_W) begin
                last_grant <= SRC_WRITE;
            end

            // A new timeout wins over a same-cycle clear.
            if (timeout_hit) begin
                op_timeoutErr <= 1'b1;
                op_timeoutSrc <= (state == GNT_W);
            end else if (in_errClear) begin
                op_timeoutErr <= 1'b0;
            end
        end
    end

    assign op_yComputeModuleEnable = (state == GNT_C);
    assign op_yWriteModuleEnable   = (state == GNT_W);
    assign op_busy                 = (state != IDLE);

endmodule

// File: tb/tb_y_bus_sched.sv
// Self-checking bench for y_bus_sched with TIMEOUT = 8.
// Table of per-cycle vectors for the basic flows, then hand-written sequences
// for timeout, done-at-expiry, clear-vs-set, reset mid-grant and sustained
// contention.
module tb_y_bus_sched;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset;
    logic creq, cdone, wreq, wdone, clr;
    logic ce, we, busy, err, src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_bus_sched #(.TIMEOUT(TO), .WDOG_W(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_computeReq           (creq),
        .in_computeDone          (cdone),
        .in_writeReq             (wreq),
        .in_writeDone            (wdone),
        .in_errClear             (clr),
        .op_yComputeModuleEnable (ce),
        .op_yWriteModuleEnable   (we),
        .op_busy                 (busy),
        .op_timeoutErr           (err),
        .op_timeoutSrc           (src)
    );

    typedef struct {
        logic rst, cr, cd, wr, wd, cl;
        logic e_ce, e_we, e_busy, e_err, e_src;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic cr, input logic cd,
                         input logic wr, input logic wd, input logic cl);
        reset = r; creq = cr; cdone = cd; wreq = wr; wdone = wd; clr = cl;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic cr, input logic cd, input logic wr,
                       input logic wd, input logic cl, input logic ece, input logic ewe,
                       input logic eb, input logic eer, input logic esr);
        vec_t v;
        v.rst = r; v.cr = cr; v.cd = cd; v.wr = wr; v.wd = wd; v.cl = cl;
        v.e_ce = ece; v.e_we = ewe; v.e_busy = eb; v.e_err = eer; v.e_src = esr;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int gcnt;
        int last_hi;
        logic [1:0] prev_g, g;
        logic [1:0] order[4];

        drive(1'b0, 0, 0, 0, 0, 0);

        //   rst cr cd wr wd cl | ce we busy err src
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset state
        add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0);  // single compute req: 1-cycle latency
        add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0);  // done -> TURN
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // TURN -> IDLE
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0);  // compute granted again
        add(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0);  // creq drop + foreign writeDone -> TURN
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0,   0, 1, 1, 0, 0);  // tie, last=C -> write
        add(1, 1, 0, 1, 1, 0,   0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // requests during TURN wait for IDLE
        add(1, 1, 0, 1, 0, 0,   1, 0, 1, 0, 0);  // tie, last=W -> compute
        add(1, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0,   0, 1, 1, 0, 0);  // tie, last=C -> write
        add(1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0);  // wreq drop -> TURN, no direct C grant
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cr, vecs[i].cd, vecs[i].wr, vecs[i].wd, vecs[i].cl);
            tick();
            check($sformatf("v%0d ce", i),   ce,   vecs[i].e_ce);
            check($sformatf("v%0d we", i),   we,   vecs[i].e_we);
            check($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d err", i),  err,  vecs[i].e_err);
            check($sformatf("v%0d src", i),  src,  vecs[i].e_src);
        end

        // Write timeout: enable high exactly TO cycles, then sticky error, src=1.
        drive(1, 0, 0, 1, 0, 0);
        tick();
        check("wto first grant", we, 1);
        n = 1;
        while (we && n < 20) begin
            tick();
            if (we) n++;
        end
        drive(1, 0, 0, 0, 0, 0);
        check("wto grant length", n, TO);
        check("wto turn busy", busy, 1);
        check("wto err", err, 1);
        check("wto src", src, 1);
        drive(1, 0, 0, 0, 0, 1);
        tick();
        check("wto err cleared", err, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();

        // Done on the TO-th grant cycle beats watchdog expiry.
        drive(1, 1, 0, 0, 0, 0);
        tick();
        for (int i = 2; i <= int'(TO); i++) tick();
        check("dexp ce on last cycle", ce, 1);
        drive(1, 0, 1, 0, 0, 0);
        tick();
        check("dexp released", ce, 0);
        check("dexp no err", err, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();

        // Compute timeout, then a write timeout coinciding with errClear.
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= int'(TO); i++) tick();
        check("cto ce on last cycle", ce, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        check("cto released", ce, 0);
        check("cto err", err, 1);
        check("cto src", src, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        for (int i = 1; i <= int'(TO); i++) tick();
        drive(1, 0, 0, 1, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 1);
        check("setwin err", err, 1);
        check("setwin src", src, 1);
        tick();
        check("setwin cleared", err, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();

        // Reset in the 3rd cycle of GNT_C: enable drops at once, no TURN.
        drive(1, 1, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("rst pre ce", ce, 1);
        drive(0, 1, 0, 1, 0, 0);
        tick();
        check("rst ce", ce, 0);
        check("rst we", we, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);

        // Both requests held from reset release: W,C,W,C, 2 dead cycles apart.
        drive(1, 1, 0, 1, 0, 0);
        prev_g  = 2'd0;
        gcnt    = 0;
        last_hi = 0;
        for (int cyc = 1; cyc <= 60 && gcnt < 4; cyc++) begin
            tick();
            if (ce && we) check("both enables high", {ce, we}, 2'b00);
            g = {we, ce};
            if (g != 2'd0 && prev_g == 2'd0) begin
                order[gcnt] = g;
                if (gcnt > 0) check($sformatf("dead cycles before grant %0d", gcnt), cyc - last_hi - 1, 2);
                else          check("first grant latency", cyc, 1);
                gcnt++;
            end
            if (g != 2'd0) last_hi = cyc;
            prev_g = g;
        end
        check("grant count", gcnt, 4);
        check("order 0 W", order[0], 2'b10);
        check("order 1 C", order[1], 2'b01);
        check("order 2 W", order[2], 2'b10);
        check("order 3 C", order[3], 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
